// File: rtl/i2c_bus_scheduler_pkg.sv
// Shared definitions for the I2C bus scheduler: field widths, FSM state
// encoding and a small width helper used for index/counter sizing.
package i2c_bus_scheduler_pkg;

    localparam int unsigned I2C_DEV_W  = 7;
    localparam int unsigned I2C_REG_W  = 8;
    localparam int unsigned I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWait  = 3'd2,
        StResp  = 3'd3,
        StGap   = 3'd4
    } sched_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_bus_scheduler_if.sv
// Requester and i2c_master signals of the bus scheduler.
//  master modport: the scheduler (drives req_ready, rsp_*, m_* and busy).
//  slave modport : requesters plus the i2c_master engine.
// Per-requester fields are packed, requester i at [W*i +: W].
interface i2c_bus_scheduler_if
    import i2c_bus_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [I2C_DEV_W*NUM_REQ-1:0] req_dev;
    logic [I2C_REG_W*NUM_REQ-1:0] req_reg;
    logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]           req_rw;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic                         rsp_err;
    logic [I2C_DATA_W-1:0]        rsp_rdata;
    logic                         m_start;
    logic [I2C_DEV_W-1:0]         m_dev;
    logic [I2C_REG_W-1:0]         m_reg;
    logic [I2C_DATA_W-1:0]        m_wdata;
    logic                         m_rw;
    logic                         m_done;
    logic [I2C_DATA_W-1:0]        m_rdata;
    logic                         m_abort;
    logic                         busy;

    modport master (
        input  req_valid, req_dev, req_reg, req_wdata, req_rw, m_done, m_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, m_start, m_dev, m_reg,
               m_wdata, m_rw, m_abort, busy
    );

    modport slave (
        output req_valid, req_dev, req_reg, req_wdata, req_rw, m_done, m_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, m_start, m_dev, m_reg,
               m_wdata, m_rw, m_abort, busy
    );

endinterface

// File: rtl/i2c_bus_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or above
// ptr_i, wrapping around.
//  req_i     : request vector
//  ptr_i     : highest-priority index this cycle
//  gnt_o     : one-hot grant (zero if no request)
//  gnt_idx_o : index of the granted request
//  any_o     : at least one request present
module i2c_bus_scheduler_rr_arbiter
    import i2c_bus_scheduler_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]          req_i,
    input  logic [idx_w(N)-1:0]   ptr_i,
    output logic [N-1:0]          gnt_o,
    output logic [idx_w(N)-1:0]   gnt_idx_o,
    output logic                  any_o
);
    localparam int unsigned IdxW = idx_w(N);

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!any_o && req_i[(32'(ptr_i) + k) % N]) begin
                any_o                          = 1'b1;
                gnt_o[(32'(ptr_i) + k) % N]    = 1'b1;
                gnt_idx_o                      = IdxW'((32'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_scheduler.sv
// Shares one i2c_master between NUM_REQ requesters. Grants single-register
// transactions round-robin, issues them to the master, aborts on timeout,
// inserts a bus-free gap and returns a done/error pulse to the owner.
//  clk   : clock, all logic on posedge
//  reset : synchronous, active-low
//  bus   : requester handshake/fields, responses and i2c_master controls
module i2c_bus_scheduler
    import i2c_bus_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input logic                 clk,
    input logic                 reset,
    i2c_bus_scheduler_if.master bus
);
    localparam int unsigned IdxW = idx_w(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned GapW = idx_w(GAP_CYCLES + 1);

    sched_state_e          state_q, state_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [IdxW-1:0]       gidx_q, gidx_d;
    logic [I2C_DEV_W-1:0]  dev_q, dev_d;
    logic [I2C_REG_W-1:0]  reg_q, reg_d;
    logic [I2C_DATA_W-1:0] wdata_q, wdata_d;
    logic                  rw_q, rw_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [GapW-1:0]       gap_q, gap_d;
    logic [I2C_DATA_W-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IdxW-1:0]    gnt_idx;
    logic               any_req;
    logic [NUM_REQ-1:0] ready;
    logic               abort;

    i2c_bus_scheduler_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req_i     (bus.req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_req)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ready   = '0;
        abort   = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    ready   = gnt;
                    gidx_d  = gnt_idx;
                    dev_d   = bus.req_dev[I2C_DEV_W*gnt_idx +: I2C_DEV_W];
                    reg_d   = bus.req_reg[I2C_REG_W*gnt_idx +: I2C_REG_W];
                    wdata_d = bus.req_wdata[I2C_DATA_W*gnt_idx +: I2C_DATA_W];
                    rw_d    = bus.req_rw[gnt_idx];
                    ptr_d   = (32'(gnt_idx) + 32'd1 == NUM_REQ) ? '0 : gnt_idx + IdxW'(1);
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                // Completion beats a timeout landing on the same cycle.
                if (bus.m_done) begin
                    rdata_d = rw_q ? bus.m_rdata : '0;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    abort   = 1'b1;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                gap_d   = '0;
                state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
            end
            StGap: begin
                if (gap_q == GapW'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gidx_q  <= '0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Response fields are forced to zero outside RESP so idle outputs stay 0.
    always_comb begin
        bus.req_ready = ready;
        bus.m_abort   = abort;
        bus.m_start   = (state_q == StIssue);
        bus.m_dev     = dev_q;
        bus.m_reg     = reg_q;
        bus.m_wdata   = wdata_q;
        bus.m_rw      = rw_q;
        bus.busy      = (state_q != StIdle);
        bus.rsp_valid = (state_q == StResp) ? (NUM_REQ'(1) << gidx_q) : '0;
        bus.rsp_err   = (state_q == StResp) && err_q;
        bus.rsp_rdata = (state_q == StResp) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
module tb_i2c_bus_scheduler;
    localparam int unsigned NR  = 2;
    localparam int unsigned TO  = 50;
    localparam int unsigned GAP = 16;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int unsigned cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_bus_scheduler_if #(.NUM_REQ(NR)) bus ();

    i2c_bus_scheduler #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [NR-1:0] who;
        logic          err;
        logic [7:0]    rdata;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.rsp_valid !== '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_valid", 32'(bus.rsp_valid), 32'(mon_e.who));
                check("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
                check("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_e.rdata));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic rw, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd);
        bus.req_dev[7*r +: 7]   = dev;
        bus.req_reg[8*r +: 8]   = rg;
        bus.req_wdata[8*r +: 8] = wd;
        bus.req_rw[r]           = rw;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 100) begin
            tick();
            n++;
        end
        if (bus.req_ready == '0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_issue(input string tag, input logic rw, input logic [6:0] dev,
                               input logic [7:0] rg, input logic [7:0] wd);
        check({tag, "_m_start"}, 32'(bus.m_start), 32'd1);
        check({tag, "_m_dev"}, 32'(bus.m_dev), 32'(dev));
        check({tag, "_m_reg"}, 32'(bus.m_reg), 32'(rg));
        check({tag, "_m_wdata"}, 32'(bus.m_wdata), 32'(wd));
        check({tag, "_m_rw"}, 32'(bus.m_rw), 32'(rw));
    endtask

    // Called in the ISSUE cycle; dly < 0 means the master never answers.
    task automatic finish_txn(input int r, input logic rw, input int dly, input logic [7:0] rd);
        rsp_t e;
        int   k;
        e.who = NR'(1) << r;
        if (dly >= 0) begin
            repeat (dly) tick();
            bus.m_done  = 1'b1;
            bus.m_rdata = rd;
            #1;
            check("no_abort_on_done", 32'(bus.m_abort), 32'd0);
            e.err   = 1'b0;
            e.rdata = rw ? rd : 8'h00;
            exp_q.push_back(e);
            tick();
            bus.m_done  = 1'b0;
            bus.m_rdata = 8'h00;
        end else begin
            k = 0;
            while (!bus.m_abort && k < int'(TO) + 20) begin
                tick();
                k++;
            end
            check("abort_latency", 32'(k), 32'(TO));
            e.err   = 1'b1;
            e.rdata = 8'h00;
            exp_q.push_back(e);
            tick();
            check("abort_one_cycle", 32'(bus.m_abort), 32'd0);
        end
    endtask

    task automatic do_txn(input int r, input logic rw, input logic [6:0] dev,
                          input logic [7:0] rg, input logic [7:0] wd,
                          input int dly, input logic [7:0] rd);
        set_req(r, rw, dev, rg, wd);
        bus.req_valid[r] = 1'b1;
        wait_ready("ready");
        check("grant", 32'(bus.req_ready), 32'd1 << r);
        tick();
        bus.req_valid[r] = 1'b0;
        check_issue("issue", rw, dev, rg, wd);
        finish_txn(r, rw, dly, rd);
    endtask

    logic [6:0]  t2_dev[NR]   = '{7'h21, 7'h22};
    logic [7:0]  t2_reg[NR]   = '{8'h10, 8'h20};
    logic [7:0]  t2_wd[NR]    = '{8'h11, 8'h22};
    logic        t2_rw[NR]    = '{1'b0, 1'b1};
    logic [7:0]  t2_rd[NR]    = '{8'h99, 8'h5C};
    int unsigned exp_ptr;
    int unsigned exp_g;
    int unsigned last_start;

    initial begin
        bus.req_valid = '0;
        bus.req_dev   = '0;
        bus.req_reg   = '0;
        bus.req_wdata = '0;
        bus.req_rw    = '0;
        bus.m_done    = 1'b0;
        bus.m_rdata   = '0;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_m_start", 32'(bus.m_start), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_m_dev", 32'(bus.m_dev), 32'd0);
        reset = 1'b1;

        // Single write from requester 0.
        do_txn(0, 1'b0, 7'h57, 8'h06, 8'h03, 20, 8'h5A);

        // Both requesters compete; reset first so the pointer starts at 0.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_ptr = 0;
        for (int r = 0; r < int'(NR); r++) set_req(r, t2_rw[r], t2_dev[r], t2_reg[r], t2_wd[r]);
        bus.req_valid = '1;
        for (int i = 0; i < 4; i++) begin
            wait_ready("t2_ready");
            exp_g   = exp_ptr;
            exp_ptr = (exp_ptr + 1) % NR;
            check("t2_grant", 32'(bus.req_ready), 32'd1 << exp_g);
            tick();
            bus.req_valid[exp_g] = 1'b0;
            check_issue("t2", t2_rw[exp_g], t2_dev[exp_g], t2_reg[exp_g], t2_wd[exp_g]);
            if (i > 0) check("t2_start_spacing", cyc - last_start, 3 + GAP + 3);
            last_start = cyc;
            finish_txn(int'(exp_g), t2_rw[exp_g], 3, t2_rd[exp_g]);
            tick();
            check("t2_gap_no_ready", 32'(bus.req_ready), 32'd0);
            check("t2_gap_busy", 32'(bus.busy), 32'd1);
            if (i < 3) bus.req_valid[exp_g] = 1'b1;
        end
        bus.req_valid = '0;

        // Read from requester 1 returns master data.
        do_txn(1, 1'b1, 7'h57, 8'h07, 8'h00, 5, 8'hA5);

        // Timeout with no completion.
        do_txn(0, 1'b1, 7'h57, 8'h08, 8'h00, -1, 8'h00);

        // Completion on the exact timeout cycle.
        do_txn(1, 1'b1, 7'h57, 8'h09, 8'h00, int'(TO), 8'h3C);

        // Spurious completions in GAP and IDLE.
        tick();
        check("spur_gap_busy", 32'(bus.busy), 32'd1);
        bus.m_done = 1'b1;
        tick();
        bus.m_done = 1'b0;
        check("spur_gap_rsp", 32'(bus.rsp_valid), 32'd0);
        repeat (GAP + 3) tick();
        check("spur_idle_busy", 32'(bus.busy), 32'd0);
        bus.m_done  = 1'b1;
        bus.m_rdata = 8'hFF;
        tick();
        bus.m_done  = 1'b0;
        bus.m_rdata = 8'h00;
        check("spur_idle_rsp", 32'(bus.rsp_valid), 32'd0);
        check("spur_idle_start", 32'(bus.m_start), 32'd0);

        // Reset in WAIT drops the transaction and restores the pointer.
        set_req(0, 1'b1, 7'h33, 8'h44, 8'h55);
        bus.req_valid[0] = 1'b1;
        wait_ready("t6_ready");
        tick();
        bus.req_valid[0] = 1'b0;
        check_issue("t6", 1'b1, 7'h33, 8'h44, 8'h55);
        repeat (5) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_m_start", 32'(bus.m_start), 32'd0);
        check("t6_m_abort", 32'(bus.m_abort), 32'd0);
        check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t6_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("t6_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("t6_m_dev", 32'(bus.m_dev), 32'd0);
        check("t6_m_reg", 32'(bus.m_reg), 32'd0);
        check("t6_m_wdata", 32'(bus.m_wdata), 32'd0);
        check("t6_m_rw", 32'(bus.m_rw), 32'd0);
        repeat (3) tick();
        check("t6_quiet", 32'(bus.rsp_valid), 32'd0);
        set_req(0, 1'b0, 7'h41, 8'h42, 8'h43);
        set_req(1, 1'b1, 7'h51, 8'h52, 8'h53);
        bus.req_valid = '1;
        wait_ready("t6_regrant");
        check("t6_first_grant", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = '0;
        check_issue("t6b", 1'b0, 7'h41, 8'h42, 8'h43);
        finish_txn(0, 1'b0, 2, 8'h77);

        repeat (GAP + 5) tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
